// File: rtl/seq_detect_pkg.sv
// Shared constants, per-cycle action type and width helper for the serial pattern detector.
package seq_detect_pkg;

    localparam int unsigned PAT_LEN_MIN = 2;
    localparam int unsigned PAT_LEN_MAX = 16;
    localparam logic [5:0]  PAT_DEFAULT = 6'b111010;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_SHIFT,
        ACT_LOAD
    } act_e;

    // Ceiling log2 with a floor of 1 so a register always has at least one bit.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/seq_prefix_match.sv
// Combinational prefix matcher: longest pattern prefix ending at x, and the pattern's
// longest proper border used to resume after an overlapping match.
module seq_prefix_match
    import seq_detect_pkg::*;
#(
    parameter int unsigned PAT_LEN = 6,
    parameter int unsigned KW      = clog2(PAT_LEN),
    parameter int unsigned LW      = clog2(PAT_LEN + 1)
) (
    input  logic [PAT_LEN-2:0] hist,
    input  logic               x,
    input  logic [KW-1:0]      k,
    input  logic [PAT_LEN-1:0] pat,
    output logic [LW-1:0]      len,
    output logic [KW-1:0]      border
);

    logic [PAT_LEN-1:0] seq;
    logic [PAT_LEN-1:0] mask;
    logic [PAT_LEN-1:0] bmask;

    assign seq = {hist, x};

    // A new prefix can be at most one longer than the current one, which also keeps
    // history bits from before the last clear out of the comparison.
    always_comb begin
        len  = '0;
        mask = '0;
        for (int unsigned l = 1; l <= PAT_LEN; l++) begin
            mask = {PAT_LEN{1'b1}} >> (PAT_LEN - l);
            if ((l <= 32'(k) + 32'd1) && ((seq & mask) == (pat >> (PAT_LEN - l))))
                len = LW'(l);
        end
    end

    always_comb begin
        border = '0;
        bmask  = '0;
        for (int unsigned l = 1; l < PAT_LEN; l++) begin
            bmask = {PAT_LEN{1'b1}} >> (PAT_LEN - l);
            if ((pat & bmask) == (pat >> (PAT_LEN - l)))
                border = KW'(l);
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// Loadable serial pattern detector with overlap/non-overlap modes.
// Optional saturating match counter enabled by SEQ_DETECT_MATCH_CNT_EN.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int unsigned        PAT_LEN = 6,
    parameter logic [PAT_LEN-1:0] PAT_RST = PAT_LEN'(PAT_DEFAULT),
    parameter int unsigned        CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               x,
    input  logic               overlap,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam int unsigned KW = clog2(PAT_LEN);
    localparam int unsigned LW = clog2(PAT_LEN + 1);

    logic [PAT_LEN-1:0] pat_q,  pat_d;
    logic [KW-1:0]      k_q,    k_d;
    logic [PAT_LEN-2:0] hist_q, hist_d;
    logic               match_q, match_d;
    logic [LW-1:0]      len;
    logic [KW-1:0]      border;
    act_e               act;

    seq_prefix_match #(
        .PAT_LEN (PAT_LEN),
        .KW      (KW),
        .LW      (LW)
    ) u_prefix (
        .hist   (hist_q),
        .x      (x),
        .k      (k_q),
        .pat    (pat_q),
        .len    (len),
        .border (border)
    );

    always_comb begin
        if (pat_load)      act = ACT_LOAD;
        else if (in_valid) act = ACT_SHIFT;
        else               act = ACT_HOLD;
    end

    always_comb begin
        pat_d   = pat_q;
        k_d     = k_q;
        hist_d  = hist_q;
        match_d = 1'b0;
        case (act)
            ACT_LOAD: begin
                pat_d  = pat_in;
                k_d    = '0;
                hist_d = '0;
            end
            ACT_SHIFT: begin
                hist_d = (PAT_LEN-1)'({hist_q, x});
                if (len == LW'(PAT_LEN)) begin
                    match_d = 1'b1;
                    if (overlap) begin
                        k_d = border;
                    end else begin
                        k_d    = '0;
                        hist_d = '0;
                    end
                end else begin
                    k_d = KW'(len);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q   <= PAT_RST;
            k_q     <= '0;
            hist_q  <= '0;
            match_q <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            k_q     <= k_d;
            hist_q  <= hist_d;
            match_q <= match_d;
        end
    end

    assign match = match_q;

`ifdef SEQ_DETECT_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Counts on the same edge that raises match, so both are visible together.
    always_ff @(posedge clk) begin
        if (rst || pat_load)
            cnt_q <= '0;
        else if (match_d && (cnt_q != '1))
            cnt_q <= cnt_q + 1'b1;
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter PAT_LEN, default 6: pattern length in bits, legal range 2..16.
REQ-002 Parameter PAT_RST, default 6'b111010: pattern value after reset, PAT_LEN bits wide, MSB is the first bit received.
REQ-003 Parameter CNT_W, default 8: width of the match counter, legal range 1..32.
REQ-004 Port clk, input, 1: clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: reset, synchronous, active-high.
REQ-006 Port in_valid, input, 1: x is sampled only when in_valid is 1.
REQ-007 Port x, input, 1: serial data bit.
REQ-008 Port overlap, input, 1: 1 means overlapping detection; 0 means non-overlapping detection.
REQ-009 Port pat_load, input, 1: loads pat_in as the new pattern.
REQ-010 Port pat_in, input, PAT_LEN: new pattern value, MSB first.
REQ-011 Port match, output, 1: registered one-cycle pulse on each detected match.
REQ-012 Port match_cnt, output, CNT_W: count of matches (see Configuration).

Function
REQ-013 The state register is the current matched-prefix length k, range 0..PAT_LEN-1; k=0 is idle.
REQ-014 On a cycle with in_valid=1 and pat_load=0, compute L, the longest prefix of the pattern equal to a suffix of the bits received since the last clear, including x, capped at PAT_LEN.
REQ-015 If L<PAT_LEN, then k SHALL become L on the next edge and match SHALL be 0.
REQ-016 If L==PAT_LEN, match SHALL be 1 in the following cycle (latency one clock after the completing bit).
REQ-017 After a full match with overlap=1, k SHALL become the longest proper border of the pattern; with overlap=0, k SHALL become 0 and the received-bit history is discarded.
REQ-018 On a cycle with in_valid=0, k and the history SHALL hold and match SHALL be 0 the next cycle; gaps SHALL NOT break a partial match.
REQ-019 pat_load=1 SHALL capture pat_in into the pattern register, clear k and the history, force match to 0 the next cycle, and discard x that cycle.
REQ-020 pat_load has priority over in_valid when both are asserted in the same cycle.
REQ-021 overlap SHALL be sampled only on the cycle a match completes; changing it mid-sequence has no other effect.
REQ-022 Mismatches SHALL fall back through borders rather than to 0: with the default pattern, input 1111010 detects once because excess leading 1s hold k=3.
REQ-023 match SHALL never be asserted for two consecutive cycles unless in_valid is 1 on both completing bits, overlap=1, and the pattern permits it.

Reset
REQ-024 While rst=1, the next edge SHALL set pattern=PAT_RST, k=0, history=0, match=0, match_cnt=0.
REQ-025 rst SHALL take priority over pat_load and in_valid; a reset mid-sequence discards any partial match.

Configuration
REQ-026 With macro SEQ_DETECT_MATCH_CNT_EN defined, match_cnt SHALL increment by 1 in the cycle match is 1.
REQ-027 With SEQ_DETECT_MATCH_CNT_EN defined, match_cnt SHALL saturate at 2^CNT_W-1 and clear on rst or pat_load.
REQ-028 Without SEQ_DETECT_MATCH_CNT_EN, the port SHALL remain but be tied to 0, and no counter flops SHALL be built.

Structure
REQ-029 Package seq_detect_pkg SHALL hold the PAT_LEN legal-range constants, the state-width function clog2(PAT_LEN), and the default pattern constant.
REQ-030 Combinational sub-module seq_prefix_match SHALL take the history plus x and the pattern, and return L (REQ-014) and the border length (REQ-017).
REQ-031 The top level SHALL own all registers: pattern, k, history, match, and match_cnt.

Verification
REQ-032 Default pattern, in_valid=1, stream 111010 after reset -> match=1 exactly one cycle after the 6th bit; match_cnt=1.
REQ-033 Default pattern, stream 1111010 then 11101111010 -> exactly two matches, one per 111010 occurrence.
REQ-034 pat_load with pat_in=6'b101010, overlap=1, stream 1010101010 -> matches after bits 6, 8, and 10; the same stream with overlap=0 -> one match after bit 6.
REQ-035 Default pattern, stream 111010 with in_valid=0 for 3 cycles between bits 3 and 4 -> a single match, no early pulse.
REQ-036 Default pattern, rst pulsed after 11101 -> no match, then 111010 -> match; pat_load together with in_valid -> pattern updated, x ignored.
REQ-037 SEQ_DETECT_MATCH_CNT_EN defined, CNT_W=2, 5 matches -> match_cnt stays at 3; without the macro -> match_cnt stays at 0.
